// File: rtl/uart_result_transmitter_pkg.sv
// Shared types and helpers for the QMC-LSM UART result path.
// Holds the frame FSM state enum, the default sync word and the baud divisor helper.
package qmc_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } tx_state_e;

  localparam logic [31:0] SYNC_DEFAULT = 32'hA5A5_5A5A;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_result_transmitter_if.sv
// Result record handshake between the pricing core (master) and the UART transmitter (slave).
// Signals: result_valid, result_ready, result_data (word i at [32*i+31:32*i]).
interface uart_result_transmitter_if #(
  parameter int NUM_WORDS = 3
) ();

  logic                   result_valid;
  logic                   result_ready;
  logic [NUM_WORDS*32-1:0] result_data;

  modport master (
    output result_valid,
    output result_data,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_data,
    output result_ready
  );

endinterface

// File: rtl/uart_result_transmitter_tx_byte.sv
// 8N1 bit serialiser: start bit, 8 data bits LSB first, stop bit, CLKS clocks each.
// Ports: clk, rst, byte_valid_i, byte_i, byte_ready_o, byte_done_o (last stop clock), tx_o.
module uart_tx_byte #(
  parameter int CLKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       byte_done_o,
  output logic       tx_o
);

  localparam int CW = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  // Done fires on the final clock of the stop bit so the
  // frame FSM can queue the next byte with minimal gap.
  assign byte_ready_o = ~active_q;
  assign byte_done_o  = active_q && (bit_q == 4'd9)
                        && (cnt_q == LAST);
  assign tx_o         = tx_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (byte_valid_i) begin
        active_d = 1'b1;
        cnt_d    = '0;
        bit_d    = '0;
        sh_d     = {1'b1, byte_i};
        tx_d     = 1'b0;
      end
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        tx_d  = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/uart_result_transmitter.sv
// Captures one result record and sends it as SYNC, data words, XOR checksum, MSB byte first.
// Ports: clk, rst, res (slave handshake), tx line, busy, frames_sent counter.
module uart_result_transmitter
  import qmc_uart_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 100_000_000,
  parameter int          BAUD_RATE   = 115200,
  parameter int          NUM_WORDS   = 3,
  parameter logic [31:0] SYNC_WORD   = SYNC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_result_transmitter_if.slave    res,
  output logic                        tx,
  output logic                        busy,
  output logic [15:0]                 frames_sent
);

  localparam int CLKS = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int NB   = (NUM_WORDS + 2) * 4;
  localparam int IW   = $clog2(NB);
  localparam int FW   = (NUM_WORDS + 2) * 32;
  localparam int DW   = NUM_WORDS * 32;

  tx_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    byte_q, byte_d;
  logic [15:0]   frames_q, frames_d;

  logic          bvalid;
  logic          bready;
  logic          bdone;
  logic [31:0]   csum;
  logic [FW-1:0] frame_w;
  logic [FW-1:0] frame_sh;

  // Whole frame laid out MSB-first so byte k is a plain left shift.
  always_comb begin
    csum    = '0;
    frame_w = '0;
    frame_w[(NUM_WORDS+1)*32 +: 32] = SYNC_WORD;
    for (int i = 0; i < NUM_WORDS; i++) begin
      csum = csum ^ data_q[32*i +: 32];
      frame_w[(NUM_WORDS-i)*32 +: 32] = data_q[32*i +: 32];
    end
    frame_w[31:0] = csum;
    frame_sh = frame_w << {idx_q, 3'b000};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    byte_d   = byte_q;
    frames_d = frames_q;
    bvalid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (res.result_valid) begin
          data_d  = res.result_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_d  = frame_sh[FW-1 -: 8];
        state_d = S_SEND;
      end
      S_SEND: begin
        bvalid = 1'b1;
        if (bready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bdone) begin
          if (idx_q == IW'(NB - 1)) begin
            frames_d = frames_q + 16'd1;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      byte_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      byte_q   <= byte_d;
      frames_q <= frames_d;
    end
  end

  assign res.result_ready = (state_q == S_IDLE);
  assign busy        = !(state_q inside {S_IDLE, S_DONE});
  assign frames_sent = frames_q;

  uart_tx_byte #(
    .CLKS(CLKS)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .byte_valid_i(bvalid),
    .byte_i      (byte_q),
    .byte_ready_o(bready),
    .byte_done_o (bdone),
    .tx_o        (tx)
  );

endmodule
